// File: rtl/frame_sync_stream_switch_if.sv
// Stream bundle for frame_sync_stream_switch: NUM_SRC AXI4-Stream video sources in, one display stream out.
interface frame_sync_stream_switch_if #(
   parameter int DATA_W  = 24,
   parameter int NUM_SRC = 3
);
   logic [NUM_SRC*DATA_W-1:0] src_data;
   logic [NUM_SRC-1:0]        src_valid;
   logic [NUM_SRC-1:0]        src_user;
   logic [NUM_SRC-1:0]        src_last;
   logic [NUM_SRC-1:0]        src_ready;
   logic [DATA_W-1:0]         out_data;
   logic                      out_valid;
   logic                      out_user;
   logic                      out_last;
   logic                      out_ready;

   // master is the switch: it sinks every source and drives the display stream
   modport master (
      input  src_data, src_valid, src_user, src_last, out_ready,
      output src_ready, out_data, out_valid, out_user, out_last
   );

   modport slave (
      output src_data, src_valid, src_user, src_last, out_ready,
      input  src_ready, out_data, out_valid, out_user, out_last
   );
endinterface

// File: rtl/frame_sync_stream_switch.sv
// Frame-aligned N:1 video stream switch; source changes only take effect at start-of-frame.
// Optional macro FRAME_SWITCH_DRAIN_IDLE_EN: non-selected sources are drained instead of back-pressured.
module frame_sync_stream_switch #(
   parameter int DATA_W      = 24,
   parameter int NUM_SRC     = 3,
   parameter int TIMEOUT_CYC = 0
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic [1:0]                 sel_req,
   frame_sync_stream_switch_if.master bus,
   output logic [1:0]                 active_sel,
   output logic                       switch_pending,
   output logic                       switch_done
);

   localparam logic [0:0] ST_SYNC = 1'b0;
   localparam logic [0:0] ST_PASS = 1'b1;

   localparam int               CNT_W      = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam int               TMO_LAST_I = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
   localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TMO_LAST_I);
   localparam logic [CNT_W-1:0] TMO_MAX    = CNT_W'(TIMEOUT_CYC);
   localparam logic [2:0]       NUM_SRC_L  = 3'(NUM_SRC);

`ifdef FRAME_SWITCH_DRAIN_IDLE_EN
   localparam logic IDLE_READY = 1'b1;
`else
   localparam logic IDLE_READY = 1'b0;
`endif

   logic [0:0]       state_q,    state_d;
   logic [1:0]       active_q,   active_d;
   logic [1:0]       pend_sel_q, pend_sel_d;
   logic             pending_q,  pending_d;
   logic             done_q,     done_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;

   logic              head_valid;
   logic              head_user;
   logic              head_last;
   logic [DATA_W-1:0] head_data;
   logic              head_ready;
   logic              out_valid_w;
   logic              accept;
   logic              boundary;
   logic              tmo_fire;
   logic              switch_now;
   logic              req_ok;
   logic [NUM_SRC-1:0] src_ready_w;

   // Head of the currently routed source
   always_comb begin
      head_valid = 1'b0;
      head_user  = 1'b0;
      head_last  = 1'b0;
      head_data  = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (active_q == 2'(i)) begin
            head_valid = bus.src_valid[i];
            head_user  = bus.src_user[i];
            head_last  = bus.src_last[i];
            head_data  = bus.src_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // An SOF on the routed source while a request waits is held back for the next selection
   assign boundary = (state_q == ST_PASS) && pending_q && head_valid && head_user;

   always_comb begin
      out_valid_w = 1'b0;
      head_ready  = 1'b0;
      if (state_q == ST_PASS) begin
         out_valid_w = head_valid && !boundary;
         head_ready  = bus.out_ready && !boundary;
      end else begin
         head_ready  = head_valid && !head_user;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         src_ready_w[i] = (active_q == 2'(i)) ? head_ready : IDLE_READY;
      end
   end

   assign bus.src_ready = src_ready_w;
   assign bus.out_valid = out_valid_w;
   assign bus.out_data  = head_data;
   assign bus.out_user  = head_user;
   assign bus.out_last  = head_last;

   assign accept = out_valid_w && bus.out_ready;

   // Fires on the idle cycle that brings the stall count up to TIMEOUT_CYC
   assign tmo_fire = (TIMEOUT_CYC > 0) && (state_q == ST_PASS) && pending_q &&
                     !accept && (cnt_q >= TMO_LAST);

   assign switch_now = ((state_q == ST_SYNC) && pending_q) || boundary || tmo_fire;
   assign req_ok     = ({1'b0, sel_req} < NUM_SRC_L);

   always_comb begin
      state_d    = state_q;
      active_d   = active_q;
      pend_sel_d = pend_sel_q;
      pending_d  = pending_q;
      done_d     = 1'b0;
      cnt_d      = '0;

      case (state_q)
         ST_SYNC: if (!pending_q && head_valid && head_user) state_d = ST_PASS;
         default: if (boundary || tmo_fire) state_d = ST_SYNC;
      endcase

      if (switch_now) begin
         active_d  = pend_sel_q;
         pending_d = 1'b0;
         done_d    = 1'b1;
      end

      // Compare against the post-switch selection so a late request queues for the next frame
      if (req_ok) begin
         if (sel_req != active_d) begin
            pend_sel_d = sel_req;
            pending_d  = 1'b1;
         end else begin
            pending_d  = 1'b0;
         end
      end

      if ((TIMEOUT_CYC > 0) && (state_q == ST_PASS) && pending_q && !accept && !switch_now) begin
         cnt_d = (cnt_q == TMO_MAX) ? cnt_q : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_SYNC;
         active_q   <= 2'd0;
         pend_sel_q <= 2'd0;
         pending_q  <= 1'b0;
         done_q     <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         active_q   <= active_d;
         pend_sel_q <= pend_sel_d;
         pending_q  <= pending_d;
         done_q     <= done_d;
         cnt_q      <= cnt_d;
      end
   end

   assign active_sel     = active_q;
   assign switch_pending = pending_q;
   assign switch_done    = done_q;

endmodule

// File: tb/tb_frame_sync_stream_switch.sv
// Randomized scoreboard bench for frame_sync_stream_switch against a frame-level reference model.
module tb_frame_sync_stream_switch;
   localparam int DATA_W      = 24;
   localparam int NUM_SRC     = 3;
   localparam int TIMEOUT_CYC = 16;
   localparam int FRAME_PIX   = 8;
   localparam int LINE_PIX    = 4;
`ifdef FRAME_SWITCH_DRAIN_IDLE_EN
   localparam bit DRAIN = 1'b1;
`else
   localparam bit DRAIN = 1'b0;
`endif

   typedef struct {
      logic [DATA_W-1:0] d;
      logic              u;
      logic              l;
   } beat_t;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [1:0] sel_req = 2'd0;
   logic [1:0] active_sel;
   logic       switch_pending;
   logic       switch_done;

   frame_sync_stream_switch_if #(.DATA_W(DATA_W), .NUM_SRC(NUM_SRC)) bus ();

   frame_sync_stream_switch #(
      .DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .resetn(resetn), .sel_req(sel_req), .bus(bus),
      .active_sel(active_sel), .switch_pending(switch_pending), .switch_done(switch_done)
   );

   always #5 clk = ~clk;

   int    tests = 0;
   int    fails = 0;
   int    cyc   = 0;
   beat_t exp_q[$];

   // Upstream source generators
   int  src_pix [NUM_SRC];
   int  src_frm [NUM_SRC];
   bit  src_v   [NUM_SRC];
   bit  hs      [NUM_SRC];
   bit  o_rdy;
   bit  last_acc;

   // Reference model: is the output locked to a frame, which source, which request waits
   bit       m_locked;
   int       m_active, m_pend, m_stall;
   bit       m_pending, m_done;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic beat_t beat_of(input int i);
      beat_t b;
      b.d = {8'(i), 8'(src_frm[i]), 8'(src_pix[i])};
      b.u = (src_pix[i] == 0);
      b.l = ((src_pix[i] % LINE_PIX) == LINE_PIX - 1);
      return b;
   endfunction

   task automatic apply_sources();
      for (int i = 0; i < NUM_SRC; i++) begin
         beat_t b;
         b = beat_of(i);
         bus.src_data[i*DATA_W +: DATA_W] = b.d;
         bus.src_user[i]  = b.u;
         bus.src_last[i]  = b.l;
         bus.src_valid[i] = src_v[i];
      end
      bus.out_ready = o_rdy;
   endtask

   task automatic model_reset();
      m_locked  = 1'b0;
      m_active  = 0;
      m_pend    = 0;
      m_pending = 1'b0;
      m_done    = 1'b0;
      m_stall   = 0;
   endtask

   task automatic drive(input int sel, input int pv, input int pr, input bit v0_off);
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (hs[i]) begin
            src_pix[i] = (src_pix[i] + 1) % FRAME_PIX;
            if (src_pix[i] == 0) src_frm[i]++;
            src_v[i] = 1'b0;
         end
         hs[i] = 1'b0;
         if (!src_v[i]) src_v[i] = (i == 0 && v0_off) ? 1'b0 : ($urandom_range(99) < pv);
      end
      o_rdy   = ($urandom_range(99) < pr);
      sel_req = 2'(sel);
      apply_sources();
   endtask

   task automatic sample();
      logic [NUM_SRC-1:0] er;
      bit hv, hu, bnd, ov, acc, forced, sw, nxt_locked;
      int new_act;
      @(negedge clk);
      if (!resetn) model_reset();
      hv = src_v[m_active];
      hu = (src_pix[m_active] == 0);
      er = DRAIN ? '1 : '0;
      if (!m_locked) begin
         bnd = 1'b0;
         ov  = 1'b0;
         er[m_active] = hv && !hu;
      end else begin
         bnd = m_pending && hv && hu;
         ov  = hv && !bnd;
         er[m_active] = o_rdy && !bnd;
      end
      acc    = ov && o_rdy;
      forced = m_locked && m_pending && !acc && (m_stall >= TIMEOUT_CYC - 1);
      sw     = (!m_locked && m_pending) || bnd || forced;

      check("active_sel", 32'(active_sel), 32'(m_active));
      check("switch_pending", 32'(switch_pending), 32'(m_pending));
      check("switch_done", 32'(switch_done), 32'(m_done));
      check("src_ready", 32'(bus.src_ready), 32'(er));
      check("out_valid", 32'(bus.out_valid), 32'(ov));
      if (acc) exp_q.push_back(beat_of(m_active));

      for (int i = 0; i < NUM_SRC; i++) hs[i] = src_v[i] && bus.src_ready[i];
      last_acc = bus.out_valid && bus.out_ready;

      if (resetn) begin
         nxt_locked = sw ? 1'b0 : (m_locked || (hv && hu));
         m_stall    = (m_locked && m_pending && !acc && !sw) ?
                      ((m_stall < TIMEOUT_CYC) ? m_stall + 1 : m_stall) : 0;
         new_act    = sw ? m_pend : m_active;
         m_done     = sw;
         if (sw) m_pending = 1'b0;
         if (int'(sel_req) < NUM_SRC) begin
            if (int'(sel_req) != new_act) begin
               m_pend    = int'(sel_req);
               m_pending = 1'b1;
            end else begin
               m_pending = 1'b0;
            end
         end
         m_active = new_act;
         m_locked = nxt_locked;
      end
   endtask

   task automatic run(input int n, input int sel, input int pv, input int pr);
      repeat (n) begin
         drive(sel, pv, pr, 1'b0);
         sample();
      end
   endtask

   // Advance until the model is locked mid-frame on source sel
   task automatic wait_mid(input int sel, input string name);
      int guard = 0;
      while (!(m_locked && m_active == sel && !m_pending &&
               src_pix[sel] >= 2 && src_pix[sel] <= 5) && guard < 300) begin
         run(1, sel, 90, 100);
         guard++;
      end
      if (guard >= 300) begin
         tests++;
         fails++;
         $display("FAIL %s: no mid-frame point within %0d cycles", name, guard);
      end
   endtask

   task automatic timeout_test();
      int  acc_cyc = 0, done_cyc = -1;
      bit  found = 1'b0;
      for (int k = 0; k < 300 && !found; k++) begin
         drive(0, 100, 100, 1'b0);
         if (m_locked && m_active == 0 && !m_pending && src_v[0] && src_pix[0] == 2) begin
            sel_req = 2'd1;
            found = 1'b1;
         end
         sample();
      end
      check("tmo_setup_found", 32'(found), 32'd1);
      drive(1, 100, 100, 1'b0);
      sample();
      acc_cyc = cyc;
      check("tmo_last_accept", 32'(last_acc), 32'd1);
      for (int k = 0; k < 40 && done_cyc < 0; k++) begin
         drive(1, 100, 100, 1'b1);
         sample();
         if (switch_done) done_cyc = cyc;
      end
      check("tmo_edges_to_switch", 32'(done_cyc - acc_cyc - 1), 32'(TIMEOUT_CYC));
      check("tmo_active_sel", 32'(active_sel), 32'd1);
   endtask

   task automatic reset_test();
      wait_mid(1, "reset_setup");
      drive(1, 100, 0, 1'b0);
      #1 resetn = 1'b0;
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_active_sel", 32'(active_sel), 32'd0);
      check("rst_pending", 32'(switch_pending), 32'd0);
      check("rst_idle_ready", 32'(bus.src_ready[2:1]), DRAIN ? 32'd3 : 32'd0);
      sample();
      run(2, 0, 100, 0);
      drive(0, 100, 100, 1'b0);
      resetn = 1'b1;
      sample();
      run(30, 0, 90, 100);
   endtask

   // Scoreboard monitor: pops one expected beat per accepted output beat
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         #1;
         if (resetn && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL scoreboard: unexpected beat %0h, nothing expected", bus.out_data);
            end else begin
               e = exp_q.pop_front();
               check("out_data", 32'(bus.out_data), 32'(e.d));
               check("out_user", 32'(bus.out_user), 32'(e.u));
               check("out_last", 32'(bus.out_last), 32'(e.l));
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < NUM_SRC; i++) begin
         src_pix[i] = (i * 3 + 5) % FRAME_PIX;
         src_frm[i] = 0;
         src_v[i]   = 1'b0;
         hs[i]      = 1'b0;
      end
      o_rdy = 1'b1;
      apply_sources();
      model_reset();

      run(3, 0, 60, 100);
      check("init_out_valid", 32'(bus.out_valid), 32'd0);
      check("init_done", 32'(switch_done), 32'd0);
      drive(0, 85, 100, 1'b0);
      resetn = 1'b1;
      sample();

      run(40, 0, 85, 100);                  // plain streaming from source 0
      wait_mid(0, "switch_setup");
      run(40, 1, 90, 100);                  // mid-frame switch to source 1
      wait_mid(1, "cancel_setup");
      run(2, 2, 90, 100);                   // request raised then withdrawn
      run(30, 1, 90, 100);
      run(12, 3, 90, 100);                  // out-of-range request
      run(40, 0, 90, 100);
      timeout_test();
      reset_test();

      for (int s = 0; s < 120; s++) begin
         run($urandom_range(30, 5), $urandom_range(3), $urandom_range(100, 40),
             $urandom_range(100, 40));
      end
      run(40, 0, 100, 100);
      #2;
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
